// File: rtl/mash_ncl.sv
// mash_ncl -- noise-cancellation / recombination network for a MASH 1-1-1
// delta-sigma modulator. Consumes the 1-bit carries of up to three cascaded
// stages, aligns them in time and applies the digital differentiators,
// producing one registered signed output per enabled clock.
//
// Parameters:
//   ORDER    number of cascaded stages consumed (1, 2 or 3)
// Ports:
//   clk      rising-edge clock shared with the MASH stages
//   rst_n    asynchronous active-low reset
//   en       sample enable; state advances only on enabled edges
//   clr      synchronous flush, priority over en
//   c1..c3   stage carries (c2 lags c1 by one cycle, c3 by two)
//   y_out    registered output, 4-bit two's complement
//   y_valid  high once the pipeline history is fully populated
//
// Optional build: define MASH_NCL_OFFSET_EN to emit y_out as offset binary
// (y + 3, range 0..7). Reset/flush value of y_out stays 0 in both builds.

module mash_ncl #(
    parameter int ORDER = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic       c1,
    input  logic       c2,
    input  logic       c3,
    output logic [3:0] y_out,
    output logic       y_valid
);

    generate
        if (ORDER < 1 || ORDER > 3) begin : g_bad_order
            $error("mash_ncl: ORDER must be 1, 2 or 3");
        end
    endgenerate

    localparam logic [2:0] FILL_MAX = 3'(ORDER + 1);

    // Alignment delay lines and differentiator history.
    logic       c1_d1, c1_d2, c2_d1;
    logic       a2_z1, a3_z1, a3_z2;
    logic [2:0] fill;

    logic       a1, a2, a3;
    logic [3:0] y;
    logic [2:0] fill_nxt;

    // Pick the aligned taps. Stages beyond ORDER contribute 0, which also
    // keeps their history registers at 0 so the sum collapses correctly.
    always_comb begin
        a1 = c1_d2;
        a2 = 1'b0;
        a3 = 1'b0;
        if (ORDER == 1) begin
            a1 = c1;
        end else if (ORDER == 2) begin
            a1 = c1_d1;
            a2 = c2;
        end else begin
            a1 = c1_d2;
            a2 = c2_d1;
            a3 = c3;
        end
    end

    // Modulo-16 arithmetic on zero-extended carries gives the correct
    // two's complement result since the true range is -3..+4.
    always_comb begin
        y = {3'b000, a1}
          + {3'b000, a2} - {3'b000, a2_z1}
          + {3'b000, a3} - {2'b00, a3_z1, 1'b0} + {3'b000, a3_z2};
    end

    always_comb begin
        fill_nxt = (fill == FILL_MAX) ? fill : fill + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_d1   <= 1'b0;
            c1_d2   <= 1'b0;
            c2_d1   <= 1'b0;
            a2_z1   <= 1'b0;
            a3_z1   <= 1'b0;
            a3_z2   <= 1'b0;
            fill    <= 3'd0;
            y_out   <= 4'd0;
            y_valid <= 1'b0;
        end else if (clr) begin
            c1_d1   <= 1'b0;
            c1_d2   <= 1'b0;
            c2_d1   <= 1'b0;
            a2_z1   <= 1'b0;
            a3_z1   <= 1'b0;
            a3_z2   <= 1'b0;
            fill    <= 3'd0;
            y_out   <= 4'd0;
            y_valid <= 1'b0;
        end else if (en) begin
            c1_d1   <= c1;
            c1_d2   <= c1_d1;
            c2_d1   <= c2;
            a2_z1   <= a2;
            a3_z1   <= a3;
            a3_z2   <= a3_z1;
            fill    <= fill_nxt;
`ifdef MASH_NCL_OFFSET_EN
            y_out   <= y + 4'd3;
`else
            y_out   <= y;
`endif
            // Registered alongside y_out so the flag describes this output.
            y_valid <= (fill_nxt == FILL_MAX);
        end
    end

endmodule

// File: tb/tb_mash_ncl.sv
// tb_mash_ncl -- directed bench for mash_ncl (ORDER=3). Expected outputs are
// hand-computed from the differentiator equations; under MASH_NCL_OFFSET_EN
// computed outputs are expected shifted by +3 while reset/flush values stay 0.

module tb_mash_ncl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       c1, c2, c3;
    logic [3:0] y_out;
    logic       y_valid;

    int checks = 0;
    int passed = 0;

`ifdef MASH_NCL_OFFSET_EN
    localparam int OFFSET = 3;
`else
    localparam int OFFSET = 0;
`endif

    mash_ncl #(.ORDER(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .c1      (c1),
        .c2      (c2),
        .c3      (c3),
        .y_out   (y_out),
        .y_valid (y_valid)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raw 4-bit comparison of y_out.
    task automatic check_raw(input string tag, input logic [3:0] exp);
        checks++;
        assert (y_out === exp) begin
            passed++;
        end else begin
            $error("FAIL %s y_out observed=%b expected=%b", tag, y_out, exp);
        end
    endtask

    // Computed output y (signed), shifted by the build offset.
    task automatic check_y(input string tag, input int yv);
        logic [3:0] exp;
        exp = 4'(yv + OFFSET);
        check_raw(tag, exp);
    endtask

    task automatic check_v(input string tag, input logic exp);
        checks++;
        assert (y_valid === exp) begin
            passed++;
        end else begin
            $error("FAIL %s y_valid observed=%b expected=%b", tag, y_valid, exp);
        end
    endtask

    // Drive one edge's inputs, clock it, sample 1 ns after the edge.
    task automatic step(input logic e, input logic cl,
                        input logic i1, input logic i2, input logic i3);
        en  = e;
        clr = cl;
        c1  = i1;
        c2  = i2;
        c3  = i3;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; clr = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
        #2;
        check_raw("reset_y", 4'd0);
        check_v("reset_valid", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle fill: zero output, valid after 4th enabled edge.
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0, 0, 0);
            check_y($sformatf("idle_y_%0d", i), 0);
            check_v($sformatf("idle_valid_%0d", i), (i >= 4));
        end

        // c3 impulse: +1, -2, +1, 0.
        step(1, 0, 0, 0, 1); check_y("c3_imp_0", 1);
        step(1, 0, 0, 0, 0); check_y("c3_imp_1", -2);
        step(1, 0, 0, 0, 0); check_y("c3_imp_2", 1);
        step(1, 0, 0, 0, 0); check_y("c3_imp_3", 0);
        check_v("c3_imp_valid", 1'b1);

        // c2 impulse: 0, +1, -1, 0.
        step(1, 0, 0, 1, 0); check_y("c2_imp_0", 0);
        step(1, 0, 0, 0, 0); check_y("c2_imp_1", 1);
        step(1, 0, 0, 0, 0); check_y("c2_imp_2", -1);
        step(1, 0, 0, 0, 0); check_y("c2_imp_3", 0);

        // c1 impulse: 0, 0, +1, 0.
        step(1, 0, 1, 0, 0); check_y("c1_imp_0", 0);
        step(1, 0, 0, 0, 0); check_y("c1_imp_1", 0);
        step(1, 0, 0, 0, 0); check_y("c1_imp_2", 1);
        step(1, 0, 0, 0, 0); check_y("c1_imp_3", 0);

        // Maximum: a1=1 a2=1 a2_z1=0 a3=1 a3_z1=0 a3_z2=1 -> +4.
        step(1, 0, 1, 0, 1); check_y("max_m2", 1);
        step(1, 0, 0, 1, 0); check_y("max_m1", -2);
        step(1, 0, 0, 0, 1); check_y("max_e", 4);
        step(1, 0, 0, 0, 0); check_y("max_p1", -3);
        step(1, 0, 0, 0, 0); check_y("max_p2", 1);
        step(1, 0, 0, 0, 0); check_y("max_p3", 0);

        // Minimum: a2_z1=1 a3_z1=1, everything else 0 -> -3.
        step(1, 0, 0, 1, 0); check_y("min_m2", 0);
        step(1, 0, 0, 0, 1); check_y("min_m1", 2);
        step(1, 0, 0, 0, 0); check_y("min_e", -3);
        step(1, 0, 0, 0, 0); check_y("min_p1", 1);
        step(1, 0, 0, 0, 0); check_y("min_p2", 0);

        // Enable freeze mid-response: inputs toggled while en=0 are ignored.
        step(1, 0, 0, 0, 1); check_y("frz_0", 1);
        step(1, 0, 0, 0, 0); check_y("frz_1", -2);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 1);
            check_y($sformatf("frz_hold_%0d", i), -2);
            check_v($sformatf("frz_hold_v_%0d", i), 1'b1);
        end
        step(1, 0, 0, 0, 0); check_y("frz_2", 1);
        step(1, 0, 0, 0, 0); check_y("frz_3", 0);

        // Flush: load c1 history, then clr with en=1 and c3=1 (not absorbed).
        step(1, 0, 1, 0, 0); check_y("clr_pre", 0);
        step(1, 1, 0, 0, 1);
        check_raw("clr_y", 4'd0);
        check_v("clr_valid", 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 0, 0);
            check_y($sformatf("refill_y_%0d", i), 0);
            check_v($sformatf("refill_v_%0d", i), (i == 4));
        end

        // Asynchronous reset between edges.
        step(1, 0, 0, 0, 1); check_y("arst_pre", 1);
        check_v("arst_pre_v", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_raw("arst_y", 4'd0);
        check_v("arst_valid", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0);
        check_y("post_arst_y", 0);
        check_v("post_arst_v", 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
